// File: rtl/overture_out_capture.sv
// Captures every change on the overture CPU out_port into a FIFO drained by a valid/ready stream.
// Optional head pc tagging is enabled by defining OVERTURE_OUTCAP_PC_TAG_EN.
module overture_out_capture #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          clear,
  input  logic [7:0]    cpu_out,
  input  logic [7:0]    cpu_pc,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [7:0]    m_data,
  output logic [7:0]    m_pc,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [7:0]    drop_count
);

`ifdef OVERTURE_OUTCAP_PC_TAG_EN
  localparam int EW = 16;
`else
  localparam int EW = 8;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [EW-1:0] wdata;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    prev_out;
  logic          prev_vld;
  logic          evt;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          flush;

  assign flush = !reset || clear;
  assign full  = count == (AW+1)'(DEPTH);
  assign evt   = run && (!prev_vld || cpu_out != prev_out);
  assign pop   = m_valid && m_ready;
  assign push  = evt && (!full || pop);
  assign drop  = evt && full && !pop;

`ifdef OVERTURE_OUTCAP_PC_TAG_EN
  assign wdata = {cpu_pc, cpu_out};
`else
  assign wdata = cpu_out;
  logic unused_pc;
  assign unused_pc = ^cpu_pc;
`endif

  // Storage carries no reset; outputs are masked while empty instead.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'h00;
      prev_out   <= 8'h00;
      prev_vld   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
      if (run) begin
        prev_out <= cpu_out;
        prev_vld <= 1'b1;
      end
    end
  end

  assign head    = mem[rd_ptr];
  assign m_valid = count != '0;
  assign level   = count;
  assign m_data  = m_valid ? head[7:0] : 8'h00;

`ifdef OVERTURE_OUTCAP_PC_TAG_EN
  assign m_pc = m_valid ? head[15:8] : 8'h00;
`else
  assign m_pc = 8'h00;
`endif

endmodule

// File: tb/tb_overture_out_capture.sv
// Randomised and directed bench for overture_out_capture.
// Reference model is a queue of captured events; pc tags follow OVERTURE_OUTCAP_PC_TAG_EN.
module tb_overture_out_capture;

  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        clear;
  logic [7:0]  cpu_out;
  logic [7:0]  cpu_pc;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [7:0]  m_pc;
  logic [AW:0] level;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] q[$];
  logic [7:0]  r_prev;
  bit          r_vld;
  bit          r_ovf;
  int          r_drops;

  always #5 clk = ~clk;

  overture_out_capture #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .clear(clear),
    .cpu_out(cpu_out),
    .cpu_pc(cpu_pc),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_pc(m_pc),
    .level(level),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_flush();
    q.delete();
    r_prev  = 8'h00;
    r_vld   = 1'b0;
    r_ovf   = 1'b0;
    r_drops = 0;
  endfunction

  function automatic void model_step();
    bit evt;
    if (!reset || clear) begin
      model_flush();
      return;
    end
    evt = run && (!r_vld || cpu_out != r_prev);
    if (q.size() > 0 && m_ready) void'(q.pop_front());
    if (evt) begin
      if (q.size() < DEPTH) begin
        q.push_back({cpu_pc, cpu_out});
      end else begin
        r_ovf = 1'b1;
        if (r_drops != 255) r_drops++;
      end
    end
    if (run) begin
      r_prev = cpu_out;
      r_vld  = 1'b1;
    end
  endfunction

  task automatic compare();
    logic [15:0] h;
    h = (q.size() > 0) ? q[0] : 16'h0000;
    chk("m_valid", 16'(m_valid), 16'(q.size() > 0));
    chk("m_data", 16'(m_data), 16'(h[7:0]));
`ifdef OVERTURE_OUTCAP_PC_TAG_EN
    chk("m_pc", 16'(m_pc), 16'(h[15:8]));
`else
    chk("m_pc", 16'(m_pc), 16'h0000);
`endif
    chk("level", 16'(level), 16'(q.size()));
    chk("overflow", 16'(overflow), 16'(r_ovf));
    chk("drop_count", 16'(drop_count), 16'(r_drops));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle();
    reset   = 1'b1;
    clear   = 1'b0;
    run     = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic drain();
    run     = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    m_ready = 1'b0;
  endtask

  task automatic push_vals(input int n, input logic [7:0] base);
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      cpu_out = base + 8'(i);
      step();
    end
    run = 1'b0;
  endtask

  initial begin
    logic [7:0] seq [5];
    seq = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h01};
    model_flush();
    idle();
    cpu_pc  = 8'h00;
    reset   = 1'b0;
    run     = 1'b1;
    cpu_out = 8'h55;
    for (int i = 0; i < 3; i++) step();
    chk("rst_valid", 16'(m_valid), 16'h0);
    chk("rst_level", 16'(level), 16'h0);
    reset = 1'b1;
    step();
    chk("rst_first", 16'(m_data), 16'h55);
    run = 1'b0;
    drain();

    do_clear();
    m_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_out = seq[i];
      step();
    end
    chk("chg_level", 16'(level), 16'd3);
    run = 1'b0;
    cpu_out = 8'h09;
    step();
    chk("run0_level", 16'(level), 16'd3);
    drain();

    do_clear();
    push_vals(18, 8'h20);
    chk("ovf_level", 16'(level), 16'd16);
    chk("ovf_flag", 16'(overflow), 16'h1);
    chk("ovf_drops", 16'(drop_count), 16'd2);
    drain();

    do_clear();
    push_vals(16, 8'h40);
    run = 1'b1;
    m_ready = 1'b1;
    cpu_out = 8'h99;
    step();
    chk("fpp_level", 16'(level), 16'd16);
    chk("fpp_ovf", 16'(overflow), 16'h0);
    chk("fpp_head", 16'(m_data), 16'h41);
    drain();

    do_clear();
    push_vals(5, 8'h60);
    run = 1'b1;
    cpu_out = 8'h77;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_level", 16'(level), 16'd0);
    chk("clr_valid", 16'(m_valid), 16'h0);
    step();
    chk("clr_fresh", 16'(level), 16'd1);
    run = 1'b0;
    drain();

    do_clear();
    run = 1'b1;
    cpu_pc = 8'h10;
    cpu_out = 8'hA5;
    step();
    chk("tag_data", 16'(m_data), 16'hA5);
`ifdef OVERTURE_OUTCAP_PC_TAG_EN
    chk("tag_pc", 16'(m_pc), 16'h10);
`else
    chk("tag_pc", 16'(m_pc), 16'h00);
`endif
    run = 1'b0;
    drain();

    do_clear();
    push_vals(DEPTH + 270, 8'h00);
    chk("sat_drops", 16'(drop_count), 16'hFF);
    drain();

    for (int i = 0; i < 3000; i++) begin
      int rp;
      rp = ((i / 200) % 3 == 0) ? 1 : ((i / 200) % 3 == 1) ? 8 : 3;
      reset   = $urandom_range(0, 199) != 0;
      clear   = $urandom_range(0, 99) == 0;
      run     = $urandom_range(0, 7) != 0;
      cpu_out = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                            : 8'($urandom_range(0, 3));
      cpu_pc  = 8'($urandom);
      m_ready = $urandom_range(0, 9) < rp;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
